branch_checkpoint_table: RTL and testbench

//  Checkpoint store feeding branch misprediction recovery. On every renamed branch, captures branch

---
 rtl/branch_checkpoint_table.sv | 98 +++++++++
 tb/tb_branch_checkpoint_table.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_checkpoint_table.sv
// Branch checkpoint table: per-branch snapshot of active-list id, free-list head and rename map,
// with delay-slot tracking, out-of-order release on resolve and bulk restore on mispredict.
module branch_checkpoint_table #(
  parameter int BRANCH_NUM         = 4,
  parameter int BRANCH_NUM_INDEX   = 2,
  parameter int REG_NUM            = 32,
  parameter int PHYS_REG_NUM_INDEX = 6,
  parameter int AL_INDEX           = 6
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic                                              alloc_valid,
  output logic                                              alloc_ready,
  input  logic [AL_INDEX-1:0]                               alloc_branch_id,
  input  logic [PHYS_REG_NUM_INDEX-1:0]                     alloc_free_head,
  input  logic [REG_NUM*PHYS_REG_NUM_INDEX-1:0]             alloc_rename,
  input  logic                                              ds_set,
  input  logic                                              resolve_valid,
  input  logic [AL_INDEX-1:0]                               resolve_branch_id,
  input  logic                                              restore_valid,
  input  logic [BRANCH_NUM-1:0]                             restore_valid_vec,
  input  logic [BRANCH_NUM_INDEX-1:0]                       restore_wr_ptr,
  output logic [BRANCH_NUM-1:0]                             valid,
  output logic [BRANCH_NUM_INDEX-1:0]                       write_pointer,
  output logic                                              full,
  output logic [BRANCH_NUM*AL_INDEX-1:0]                    branch_id,
  output logic [BRANCH_NUM*PHYS_REG_NUM_INDEX-1:0]          free_head_pointer,
  output logic [BRANCH_NUM*REG_NUM*PHYS_REG_NUM_INDEX-1:0]  rename_buffer,
  output logic [BRANCH_NUM-1:0]                             ds_valid
);

  localparam int MAP_W = REG_NUM * PHYS_REG_NUM_INDEX;

  logic [BRANCH_NUM-1:0]                    valid_q, valid_nxt;
  logic [BRANCH_NUM-1:0]                    ds_valid_q, ds_valid_nxt;
  logic [BRANCH_NUM_INDEX-1:0]              wr_ptr_q;
  logic [BRANCH_NUM_INDEX-1:0]              youngest;
  logic [BRANCH_NUM*AL_INDEX-1:0]           branch_id_q;
  logic [BRANCH_NUM*PHYS_REG_NUM_INDEX-1:0] free_head_q;
  logic [BRANCH_NUM*MAP_W-1:0]              rename_q;
  logic                                     alloc_fire;

  assign full        = valid_q[wr_ptr_q];
  assign alloc_ready = !full && !restore_valid;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign youngest    = wr_ptr_q - 1'b1;

  // ds_set targets the entry allocated before this cycle; a resolve of that same entry wins.
  always_comb begin
    valid_nxt    = valid_q;
    ds_valid_nxt = ds_valid_q;
    if (ds_set && valid_q[youngest]) ds_valid_nxt[youngest] = 1'b1;
    if (resolve_valid) begin
      for (int i = 0; i < BRANCH_NUM; i++) begin
        if (valid_q[i] && (branch_id_q[i*AL_INDEX +: AL_INDEX] == resolve_branch_id)) begin
          valid_nxt[i]    = 1'b0;
          ds_valid_nxt[i] = 1'b0;
        end
      end
    end
    if (alloc_fire) begin
      valid_nxt[wr_ptr_q]    = 1'b1;
      ds_valid_nxt[wr_ptr_q] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q     <= '0;
      ds_valid_q  <= '0;
      wr_ptr_q    <= '0;
      branch_id_q <= '0;
      free_head_q <= '0;
      rename_q    <= '0;
    end else if (restore_valid) begin
      valid_q    <= restore_valid_vec;
      wr_ptr_q   <= restore_wr_ptr;
      ds_valid_q <= ds_valid_q & restore_valid_vec;
    end else begin
      valid_q    <= valid_nxt;
      ds_valid_q <= ds_valid_nxt;
      if (alloc_fire) begin
        wr_ptr_q                                                          <= wr_ptr_q + 1'b1;
        branch_id_q[wr_ptr_q*AL_INDEX +: AL_INDEX]                        <= alloc_branch_id;
        free_head_q[wr_ptr_q*PHYS_REG_NUM_INDEX +: PHYS_REG_NUM_INDEX]    <= alloc_free_head;
        rename_q[wr_ptr_q*MAP_W +: MAP_W]                                 <= alloc_rename;
      end
    end
  end

  assign valid             = valid_q;
  assign ds_valid          = ds_valid_q;
  assign write_pointer     = wr_ptr_q;
  assign branch_id         = branch_id_q;
  assign free_head_pointer = free_head_q;
  assign rename_buffer     = rename_q;

endmodule

// File: tb/tb_branch_checkpoint_table.sv
// Scoreboard bench for branch_checkpoint_table: driver pushes expected state from an array model,
// monitor pops and compares each cycle.
module tb_branch_checkpoint_table;
  localparam int BN = 4, BI = 2, RN = 32, P = 6, AL = 6;
  localparam int MW = RN * P;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n, alloc_valid, alloc_ready, ds_set, resolve_valid, restore_valid, full;
  logic [AL-1:0]        alloc_branch_id, resolve_branch_id;
  logic [P-1:0]         alloc_free_head;
  logic [MW-1:0]        alloc_rename;
  logic [BN-1:0]        restore_valid_vec, valid, ds_valid;
  logic [BI-1:0]        restore_wr_ptr, write_pointer;
  logic [BN*AL-1:0]     branch_id;
  logic [BN*P-1:0]      free_head_pointer;
  logic [BN*MW-1:0]     rename_buffer;

  branch_checkpoint_table dut (
    .clk(clk), .rst_n(rst_n), .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_branch_id(alloc_branch_id), .alloc_free_head(alloc_free_head), .alloc_rename(alloc_rename),
    .ds_set(ds_set), .resolve_valid(resolve_valid), .resolve_branch_id(resolve_branch_id),
    .restore_valid(restore_valid), .restore_valid_vec(restore_valid_vec), .restore_wr_ptr(restore_wr_ptr),
    .valid(valid), .write_pointer(write_pointer), .full(full), .branch_id(branch_id),
    .free_head_pointer(free_head_pointer), .rename_buffer(rename_buffer), .ds_valid(ds_valid)
  );

  typedef struct {
    logic          rst_n, alloc_valid, ds_set, res_v, rest_v;
    logic [AL-1:0] id, res_id;
    logic [P-1:0]  fh;
    logic [MW-1:0] ren;
    logic [BN-1:0] rest_vec;
    logic [BI-1:0] rest_ptr;
  } stim_t;

  typedef struct {
    logic [BN-1:0]    valid, ds;
    logic [BI-1:0]    wp;
    logic             full, ready;
    logic [BN*AL-1:0] bid;
    logic [BN*P-1:0]  fh;
    logic [BN*MW-1:0] ren;
  } exp_t;

  exp_t exp_q[$];
  int n_tests = 0, n_fail = 0;

  // Reference model: plain per-entry arrays and an integer pointer.
  bit            m_valid[BN];
  bit            m_ds[BN];
  int            m_wp;
  logic [AL-1:0] m_id[BN];
  logic [P-1:0]  m_fh[BN];
  logic [P-1:0]  m_map[BN][RN];

  function automatic stim_t idle();
    stim_t s;
    s.rst_n = 1'b1; s.alloc_valid = 1'b0; s.ds_set = 1'b0; s.res_v = 1'b0; s.rest_v = 1'b0;
    s.id = '0; s.res_id = '0; s.fh = '0; s.ren = '0; s.rest_vec = '0; s.rest_ptr = '0;
    return s;
  endfunction

  function automatic logic [MW-1:0] rand_map();
    logic [MW-1:0] m;
    for (int r = 0; r < RN; r++) m[r*P +: P] = P'($urandom);
    return m;
  endfunction

  task automatic model_reset();
    m_wp = 0;
    for (int e = 0; e < BN; e++) begin
      m_valid[e] = 0; m_ds[e] = 0; m_id[e] = '0; m_fh[e] = '0;
      for (int r = 0; r < RN; r++) m_map[e][r] = '0;
    end
  endtask

  task automatic model_update(input stim_t s);
    bit old_valid[BN];
    bit ready;
    int y;
    if (!s.rst_n) begin
      model_reset();
      return;
    end
    if (s.rest_v) begin
      for (int e = 0; e < BN; e++) begin
        m_valid[e] = s.rest_vec[e];
        m_ds[e]    = m_ds[e] && s.rest_vec[e];
      end
      m_wp = int'(s.rest_ptr);
      return;
    end
    old_valid = m_valid;
    ready = !m_valid[m_wp];
    y = (m_wp + BN - 1) % BN;
    if (s.ds_set && old_valid[y]) m_ds[y] = 1;
    if (s.res_v)
      for (int e = 0; e < BN; e++)
        if (old_valid[e] && m_id[e] == s.res_id) begin
          m_valid[e] = 0; m_ds[e] = 0;
        end
    if (s.alloc_valid && ready) begin
      m_valid[m_wp] = 1; m_ds[m_wp] = 0;
      m_id[m_wp] = s.id; m_fh[m_wp] = s.fh;
      for (int r = 0; r < RN; r++) m_map[m_wp][r] = s.ren[r*P +: P];
      m_wp = (m_wp + 1) % BN;
    end
  endtask

  task automatic step(input stim_t s);
    exp_t e;
    @(negedge clk);
    rst_n = s.rst_n; alloc_valid = s.alloc_valid; alloc_branch_id = s.id; alloc_free_head = s.fh;
    alloc_rename = s.ren; ds_set = s.ds_set; resolve_valid = s.res_v; resolve_branch_id = s.res_id;
    restore_valid = s.rest_v; restore_valid_vec = s.rest_vec; restore_wr_ptr = s.rest_ptr;
    for (int i = 0; i < BN; i++) begin
      e.valid[i] = m_valid[i];
      e.ds[i]    = m_ds[i];
      e.bid[i*AL +: AL] = m_id[i];
      e.fh[i*P +: P]    = m_fh[i];
      for (int r = 0; r < RN; r++) e.ren[(i*RN + r)*P +: P] = m_map[i][r];
    end
    e.wp    = BI'(m_wp);
    e.full  = m_valid[m_wp];
    e.ready = !m_valid[m_wp] && !s.rest_v;
    exp_q.push_back(e);
    model_update(s);
  endtask

  task automatic chk(input string name, input logic [BN*MW-1:0] act, input logic [BN*MW-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      if (name == "rename_buffer")
        $display("FAIL %s: got %h required %h", name, act, req);
      else
        $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("valid", valid, e.valid);
        chk("ds_valid", ds_valid, e.ds);
        chk("write_pointer", write_pointer, e.wp);
        chk("full", full, e.full);
        chk("alloc_ready", alloc_ready, e.ready);
        chk("branch_id", branch_id, e.bid);
        chk("free_head_pointer", free_head_pointer, e.fh);
        chk("rename_buffer", rename_buffer, e.ren);
      end
    end
  end

  initial begin : driver
    stim_t s;
    rst_n = 1'b0; alloc_valid = 1'b0; alloc_branch_id = '0; alloc_free_head = '0; alloc_rename = '0;
    ds_set = 1'b0; resolve_valid = 1'b0; resolve_branch_id = '0; restore_valid = 1'b0;
    restore_valid_vec = '0; restore_wr_ptr = '0;
    repeat (2) @(posedge clk);
    model_reset();

    step(idle());
    // single alloc with known snapshot, ds tracking, resolve hit and miss
    s = idle(); s.alloc_valid = 1; s.id = 7; s.fh = 6'h12; s.ren = rand_map(); s.ren[5*P +: P] = 6'h2A;
    step(s);
    step(idle());
    s = idle(); s.ds_set = 1; step(s);
    step(idle());
    s = idle(); s.res_v = 1; s.res_id = 7; step(s);
    step(idle());
    s = idle(); s.res_v = 1; s.res_id = 40; step(s);
    step(idle());
    // fill the table, then one alloc that must be dropped
    s = idle(); s.rst_n = 0; step(s);
    foreach (s.rest_vec[k]) begin end
    for (int k = 0; k < 5; k++) begin
      s = idle(); s.alloc_valid = 1; s.fh = P'($urandom); s.ren = rand_map();
      case (k) 0: s.id = 3; 1: s.id = 5; 2: s.id = 9; 3: s.id = 12; default: s.id = 1; endcase
      step(s);
    end
    step(idle());
    // restore wins over a same-cycle alloc
    s = idle(); s.rest_v = 1; s.rest_vec = 4'b0011; s.rest_ptr = 2; s.alloc_valid = 1; s.id = 33;
    step(s);
    step(idle());
    s = idle(); s.alloc_valid = 1; s.id = 30; s.ren = rand_map(); step(s);
    s = idle(); s.alloc_valid = 1; s.id = 20; s.ren = rand_map(); s.res_v = 1; s.res_id = 5; step(s);
    step(idle());
    // reset with alloc request pending
    s = idle(); s.rst_n = 0; s.alloc_valid = 1; s.id = 11; s.fh = 6'h3F; s.ren = rand_map(); step(s);
    step(idle());

    for (int n = 0; n < 3000; n++) begin
      s = idle();
      s.rst_n       = ($urandom_range(0, 199) != 0);
      s.alloc_valid = ($urandom_range(0, 2) != 0);
      s.id          = AL'($urandom_range(0, 15));
      s.fh          = P'($urandom);
      s.ren         = rand_map();
      s.ds_set      = ($urandom_range(0, 3) == 0);
      s.res_v       = ($urandom_range(0, 2) == 0);
      s.res_id      = $urandom_range(0, 1) ? m_id[$urandom_range(0, BN-1)] : AL'($urandom);
      s.rest_v      = ($urandom_range(0, 19) == 0);
      s.rest_vec    = BN'($urandom);
      s.rest_ptr    = BI'($urandom);
      step(s);
    end
    step(idle());

    repeat (3) @(negedge clk);
    #3;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
